// File: rtl/heat_grid_scanner.sv
// heat_grid_scanner
// Snapshot stage for the 4x4 heat-stencil solver. It lets the solver run for
// RUN_CYCLES clocks, then freezes it, reads all 16 cells through the solver
// read port and streams them out as bytes with valid/ready handshaking. Each
// frame ends with a checksum byte, and completing a frame updates the
// hottest-cell statistics.
//
// Ports
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   i_enable         keep cycling run/snapshot; low stops at the next frame end
//   o_solver_mode    2'b00 run, 2'b10 frozen read-back (nothing else is driven)
//   o_solver_addr    cell index {y[1:0],x[1:0]} presented to the solver
//   i_solver_data    temperature of o_solver_addr, READ_LAT clocks after change
//   o_out_valid/i_out_ready/o_out_data/o_out_last   byte stream to the sink
//   o_frame_count    completed frames, wraps 255->0
//   o_max_temp/o_max_addr  hottest cell of the last completed frame
//   o_busy           high whenever the FSM is not IDLE
//
// state | meaning
// IDLE  | solver frozen, waiting for i_enable
// RUN   | solver running for RUN_CYCLES clocks
// WAIT  | address held while the solver read port settles
// CAPT  | cell byte captured, sum and running max updated
// EMIT  | cell byte offered until accepted
// SUM   | checksum byte offered until accepted, frame ends

module heat_grid_scanner #(
    parameter int RUN_CYCLES = 64,
    parameter int READ_LAT   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_enable,
    output logic [1:0] o_solver_mode,
    output logic [3:0] o_solver_addr,
    input  logic [2:0] i_solver_data,
    output logic       o_out_valid,
    input  logic       i_out_ready,
    output logic [7:0] o_out_data,
    output logic       o_out_last,
    output logic [7:0] o_frame_count,
    output logic [2:0] o_max_temp,
    output logic [3:0] o_max_addr,
    output logic       o_busy
);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_WAIT, S_CAPT, S_EMIT, S_SUM} state_t;

    localparam int            RW       = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
    localparam logic [RW-1:0] RUN_LOAD = RW'((RUN_CYCLES > 0) ? RUN_CYCLES - 1 : 0);
    localparam logic [1:0]    LAT_LOAD = 2'(READ_LAT - 1);
    localparam state_t        FRAME_START = (RUN_CYCLES > 0) ? S_RUN : S_WAIT;

    state_t          r_state;
    state_t          w_state_next;
    logic [RW-1:0]   r_run_cnt;
    logic [1:0]      r_lat_cnt;
    logic [3:0]      r_addr;
    logic [6:0]      r_sum;
    logic [2:0]      r_run_max;
    logic [3:0]      r_run_addr;
    logic            r_out_valid;
    logic [7:0]      r_out_data;
    logic            r_out_last;
    logic [7:0]      r_frame_count;
    logic [2:0]      r_max_temp;
    logic [3:0]      r_max_addr;
    logic            w_accept;
    logic            w_frame_start;

    assign w_accept = r_out_valid & i_out_ready;

    // A new frame begins either from IDLE or straight out of an accepted
    // checksum byte while enable is still high.
    assign w_frame_start = ((r_state == S_IDLE) & i_enable) |
                           ((r_state == S_SUM) & w_accept & i_enable);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (i_enable) w_state_next = FRAME_START;
            S_RUN:  if (r_run_cnt == '0) w_state_next = S_WAIT;
            S_WAIT: if (r_lat_cnt == '0) w_state_next = S_CAPT;
            S_CAPT: w_state_next = S_EMIT;
            S_EMIT: if (w_accept) w_state_next = (r_addr == 4'd15) ? S_SUM : S_WAIT;
            S_SUM:  if (w_accept) w_state_next = i_enable ? FRAME_START : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run_cnt     <= RUN_LOAD;
            r_lat_cnt     <= LAT_LOAD;
            r_addr        <= 4'd0;
            r_sum         <= 7'd0;
            r_run_max     <= 3'd0;
            r_run_addr    <= 4'd0;
            r_out_valid   <= 1'b0;
            r_out_data    <= 8'd0;
            r_out_last    <= 1'b0;
            r_frame_count <= 8'd0;
            r_max_temp    <= 3'd0;
            r_max_addr    <= 4'd0;
        end else begin
            // Down-counters reload whenever their state is not active, so each
            // entry into RUN/WAIT starts from a full count.
            r_run_cnt <= (r_state == S_RUN)  ? r_run_cnt - 1'b1 : RUN_LOAD;
            r_lat_cnt <= (r_state == S_WAIT) ? r_lat_cnt - 1'b1 : LAT_LOAD;

            if (w_frame_start) begin
                r_sum      <= 7'd0;
                r_run_max  <= 3'd0;
                r_run_addr <= 4'd0;
                r_addr     <= 4'd0;
            end

            case (r_state)
                S_CAPT: begin
                    r_out_data  <= {1'b0, r_addr, i_solver_data};
                    r_out_valid <= 1'b1;
                    r_sum       <= r_sum + {4'b0000, i_solver_data};
                    // Strict compare keeps the lowest address on ties.
                    if (i_solver_data > r_run_max) begin
                        r_run_max  <= i_solver_data;
                        r_run_addr <= r_addr;
                    end
                end
                S_EMIT: begin
                    if (w_accept) begin
                        if (r_addr == 4'd15) begin
                            // valid stays high: the checksum follows directly.
                            r_out_data <= {1'b1, r_sum};
                            r_out_last <= 1'b1;
                        end else begin
                            r_addr      <= r_addr + 4'd1;
                            r_out_valid <= 1'b0;
                        end
                    end
                end
                S_SUM: begin
                    if (w_accept) begin
                        r_frame_count <= r_frame_count + 8'd1;
                        r_max_temp    <= r_run_max;
                        r_max_addr    <= r_run_addr;
                        r_out_valid   <= 1'b0;
                        r_out_last    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_solver_mode = (r_state == S_RUN) ? 2'b00 : 2'b10;
    assign o_solver_addr = r_addr;
    assign o_out_valid   = r_out_valid;
    assign o_out_data    = r_out_data;
    assign o_out_last    = r_out_last;
    assign o_frame_count = r_frame_count;
    assign o_max_temp    = r_max_temp;
    assign o_max_addr    = r_max_addr;
    assign o_busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_heat_grid_scanner.sv
// Bench for heat_grid_scanner. Instance A (no run phase) carries the byte
// stream tests; instance B (64-clock run phase) carries the run-length,
// frame latency and consecutive-frame tests.

module tb_heat_grid_scanner;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [2:0] grid [16];

    logic       en_a, rdy_a, val_a, last_a, busy_a;
    logic [1:0] mode_a;
    logic [3:0] addr_a, ma_a;
    logic [2:0] sd_a, mt_a;
    logic [7:0] data_a, fc_a;

    logic       en_b, rdy_b, val_b, last_b, busy_b;
    logic [1:0] mode_b;
    logic [3:0] addr_b, ma_b;
    logic [2:0] sd_b, mt_b;
    logic [7:0] data_b, fc_b;

    heat_grid_scanner #(.RUN_CYCLES(0), .READ_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .i_enable(en_a), .o_solver_mode(mode_a),
        .o_solver_addr(addr_a), .i_solver_data(sd_a), .o_out_valid(val_a),
        .i_out_ready(rdy_a), .o_out_data(data_a), .o_out_last(last_a),
        .o_frame_count(fc_a), .o_max_temp(mt_a), .o_max_addr(ma_a), .o_busy(busy_a)
    );

    heat_grid_scanner #(.RUN_CYCLES(64), .READ_LAT(1)) dut_b (
        .clk(clk), .rst(rst), .i_enable(en_b), .o_solver_mode(mode_b),
        .o_solver_addr(addr_b), .i_solver_data(sd_b), .o_out_valid(val_b),
        .i_out_ready(rdy_b), .o_out_data(data_b), .o_out_last(last_b),
        .o_frame_count(fc_b), .o_max_temp(mt_b), .o_max_addr(ma_b), .o_busy(busy_b)
    );

    // Solver read port: one clock of read latency.
    always @(posedge clk) begin
        sd_a <= grid[addr_a];
        sd_b <= grid[addr_b];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    int rdy_pct = 100;
    always @(posedge clk) begin
        #1 rdy_a <= (int'($urandom_range(0, 99)) < rdy_pct);
    end

    logic [8:0] sb [$];
    logic       stall_a = 1'b0;
    logic [7:0] hold_data_a;
    logic       hold_last_a;
    logic [7:0] sum_seen_a = 8'd0;
    logic [7:0] fc_prev_a = 8'd0;
    logic [7:0] fc_nx_a;
    assign fc_nx_a = fc_prev_a + 8'd1;

    always @(negedge clk) begin
        if (rst) begin
            stall_a   <= 1'b0;
            fc_prev_a <= 8'd0;
        end else begin
            chk("mode_legal_a", 32'(mode_a[0]), 32'd0);
            if (stall_a) begin
                chk("stall_valid", 32'(val_a), 32'd1);
                chk("stall_data", 32'(data_a), 32'(hold_data_a));
                chk("stall_last", 32'(last_a), 32'(hold_last_a));
            end
            if (val_a && rdy_a) begin
                if (sb.size() == 0)
                    chk("extra_byte", 32'({last_a, data_a}), 32'h200);
                else
                    chk("byte", 32'({last_a, data_a}), 32'(sb.pop_front()));
                if (last_a) sum_seen_a <= data_a;
            end
            stall_a     <= val_a && !rdy_a;
            hold_data_a <= data_a;
            hold_last_a <= last_a;
            if (fc_a != fc_prev_a) begin
                chk("fc_step_a", 32'(fc_a), 32'(fc_nx_a));
                fc_prev_a <= fc_a;
            end
        end
    end

    int run_len_b = 0;
    int runs_b = 0;
    always @(negedge clk) begin
        if (rst) begin
            run_len_b <= 0;
        end else begin
            chk("mode_legal_b", 32'(mode_b[0]), 32'd0);
            if (mode_b == 2'b00) begin
                run_len_b <= run_len_b + 1;
            end else begin
                if (run_len_b != 0) begin
                    chk("run_len_b", 32'(run_len_b), 32'd64);
                    runs_b <= runs_b + 1;
                end
                run_len_b <= 0;
            end
        end
    end

    task automatic load_grid(input logic [2:0] fill, input int hot_idx, input logic [2:0] hot_val);
        for (int i = 0; i < 16; i++) grid[i] = fill;
        grid[hot_idx] = hot_val;
    endtask

    task automatic push_frame();
        logic [6:0] s;
        s = 7'd0;
        for (int i = 0; i < 16; i++) begin
            sb.push_back({1'b0, 1'b0, 4'(i), grid[i]});
            s = s + 7'(grid[i]);
        end
        sb.push_back({1'b1, 1'b1, s});
    endtask

    task automatic wait_idle_a(input int budget);
        int n;
        n = 0;
        while (busy_a && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("idle_a_timeout", 32'(busy_a), 32'd0);
    endtask

    task automatic run_one_a();
        @(negedge clk);
        en_a = 1'b1;
        @(negedge clk);
        en_a = 1'b0;
        wait_idle_a(3000);
    endtask

    typedef struct {
        logic [2:0] fill;
        int         hot_idx;
        logic [2:0] hot_val;
        int         pct;
        logic [7:0] exp_sum;
        logic [2:0] exp_mt;
        logic [3:0] exp_ma;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [6];
        int   exp_fc;
        int   n;
        int   left;

        vecs[0] = '{fill:3'd5, hot_idx:0,  hot_val:3'd5, pct:100, exp_sum:8'hD0, exp_mt:3'd5, exp_ma:4'd0};
        vecs[1] = '{fill:3'd0, hot_idx:6,  hot_val:3'd7, pct:100, exp_sum:8'h87, exp_mt:3'd7, exp_ma:4'd6};
        vecs[2] = '{fill:3'd5, hot_idx:0,  hot_val:3'd5, pct:30,  exp_sum:8'hD0, exp_mt:3'd5, exp_ma:4'd0};
        vecs[3] = '{fill:3'd7, hot_idx:0,  hot_val:3'd7, pct:100, exp_sum:8'hF0, exp_mt:3'd7, exp_ma:4'd0};
        vecs[4] = '{fill:3'd0, hot_idx:15, hot_val:3'd3, pct:50,  exp_sum:8'h83, exp_mt:3'd3, exp_ma:4'd15};
        vecs[5] = '{fill:3'd2, hot_idx:9,  hot_val:3'd6, pct:70,  exp_sum:8'hA4, exp_mt:3'd6, exp_ma:4'd9};

        rst = 1'b1;
        en_a = 1'b0;
        en_b = 1'b0;
        rdy_b = 1'b1;
        load_grid(3'd0, 0, 3'd0);
        #22 rst = 1'b0;
        @(negedge clk);

        chk("rst_mode", 32'(mode_a), 32'd2);
        chk("rst_addr", 32'(addr_a), 32'd0);
        chk("rst_valid", 32'(val_a), 32'd0);
        chk("rst_data", 32'(data_a), 32'd0);
        chk("rst_last", 32'(last_a), 32'd0);
        chk("rst_fc", 32'(fc_a), 32'd0);
        chk("rst_max_temp", 32'(mt_a), 32'd0);
        chk("rst_max_addr", 32'(ma_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_mode_b", 32'(mode_b), 32'd2);

        // T1: reset while a byte is stalled in EMIT.
        load_grid(3'd4, 0, 3'd4);
        rdy_pct = 0;
        @(negedge clk);
        en_a = 1'b1;
        @(negedge clk);
        en_a = 1'b0;
        n = 0;
        while (!val_a && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t1_reach_emit", 32'(val_a), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t1_valid", 32'(val_a), 32'd0);
        chk("t1_mode", 32'(mode_a), 32'd2);
        chk("t1_fc", 32'(fc_a), 32'd0);
        chk("t1_busy", 32'(busy_a), 32'd0);
        chk("t1_last", 32'(last_a), 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        rdy_pct = 100;
        exp_fc = 0;
        @(negedge clk);

        // T2..T4 and extra patterns: one frame per vector.
        for (int v = 0; v < 6; v++) begin
            load_grid(vecs[v].fill, vecs[v].hot_idx, vecs[v].hot_val);
            rdy_pct = vecs[v].pct;
            push_frame();
            run_one_a();
            exp_fc++;
            @(negedge clk);
            chk("vec_sb_empty", 32'(sb.size()), 32'd0);
            chk("vec_sum_byte", 32'(sum_seen_a), 32'(vecs[v].exp_sum));
            chk("vec_fc", 32'(fc_a), 32'(exp_fc));
            chk("vec_max_temp", 32'(mt_a), 32'(vecs[v].exp_mt));
            chk("vec_max_addr", 32'(ma_a), 32'(vecs[v].exp_ma));
            chk("vec_mode_idle", 32'(mode_a), 32'd2);
        end

        // T6: drop enable during cell 8; frame still completes, then stays idle.
        load_grid(3'd3, 12, 3'd6);
        rdy_pct = 100;
        push_frame();
        @(negedge clk);
        en_a = 1'b1;
        n = 0;
        while (addr_a != 4'd8 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t6_reach_cell8", 32'(addr_a), 32'd8);
        en_a = 1'b0;
        wait_idle_a(500);
        exp_fc++;
        @(negedge clk);
        chk("t6_sb_empty", 32'(sb.size()), 32'd0);
        chk("t6_sum_byte", 32'(sum_seen_a), 32'hB3);
        chk("t6_fc", 32'(fc_a), 32'(exp_fc));
        chk("t6_max_temp", 32'(mt_a), 32'd6);
        chk("t6_max_addr", 32'(ma_a), 32'd12);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            chk("t6_idle_busy", 32'(busy_a), 32'd0);
            chk("t6_idle_mode", 32'(mode_a), 32'd2);
        end

        // Frame counter wrap: keep enable high until 255, then let one more frame finish.
        load_grid(3'd1, 0, 3'd1);
        left = 256 - exp_fc;
        for (int f = 0; f < left; f++) push_frame();
        @(negedge clk);
        en_a = 1'b1;
        n = 0;
        while (fc_a != 8'd255 && n < left * 80) begin
            @(negedge clk);
            n++;
        end
        chk("wrap_reach_255", 32'(fc_a), 32'd255);
        en_a = 1'b0;
        wait_idle_a(200);
        @(negedge clk);
        chk("wrap_fc", 32'(fc_a), 32'd0);
        chk("wrap_sb_empty", 32'(sb.size()), 32'd0);
        chk("wrap_max_temp", 32'(mt_a), 32'd1);
        chk("wrap_max_addr", 32'(ma_a), 32'd0);

        // T5: 64-clock run phase before each of three back-to-back frames.
        @(negedge clk);
        en_b = 1'b1;
        @(negedge clk);
        n = 0;
        while (fc_b == 8'd0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("t5_latency", 32'(n), 32'd113);
        n = 0;
        while (fc_b != 8'd2 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("t5_reach_2", 32'(fc_b), 32'd2);
        en_b = 1'b0;
        n = 0;
        while (busy_b && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("t5_idle", 32'(busy_b), 32'd0);
        @(negedge clk);
        chk("t5_fc", 32'(fc_b), 32'd3);
        chk("t5_runs", 32'(runs_b), 32'd3);
        chk("t5_max_temp", 32'(mt_b), 32'd1);
        chk("t5_max_addr", 32'(ma_b), 32'd0);
        chk("t5_mode_idle", 32'(mode_b), 32'd2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
